// File: rtl/lcd_bus_if.sv
// lcd_bus_if: byte-command handshake plus HD44780 pin bundle between an upstream writer and lcd_bus_driver
//  cmd_valid/cmd_rs/cmd_data  upstream -> driver: byte offered, register select, byte value
//  cmd_ready/init_done        driver -> upstream: byte accepted this cycle, power-on init finished
//  lcd_data/lcd_rs/lcd_rw/lcd_e  driver -> LCD pins
interface lcd_bus_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  modport master (output cmd_valid, cmd_rs, cmd_data,
                  input  cmd_ready, init_done, lcd_data, lcd_rs, lcd_rw, lcd_e);
  modport slave  (input  cmd_valid, cmd_rs, cmd_data,
                  output cmd_ready, init_done, lcd_data, lcd_rs, lcd_rw, lcd_e);
endinterface

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: runs the HD44780 8-bit power-on init, then writes one byte per valid/ready transfer with setup/e-pulse/hold/execute timing
//  clk    system clock
//  rst_n  asynchronous active-low reset
//  bus    lcd_bus_if.slave: command handshake in, LCD pins and init_done out (lcd_rw tied low)
module lcd_bus_driver #(
  parameter int PWRUP_CYC     = 750000,
  parameter int SETUP_CYC     = 3,
  parameter int E_HIGH_CYC    = 25,
  parameter int HOLD_CYC      = 3,
  parameter int EXEC_CYC      = 2000,
  parameter int CLEAR_CYC     = 82000,
  parameter int INIT_LONG_CYC = 205000
) (
  input logic     clk,
  input logic     rst_n,
  lcd_bus_if.slave bus
);
  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  localparam int MAXC = mx(mx(mx(PWRUP_CYC, SETUP_CYC), mx(E_HIGH_CYC, HOLD_CYC)),
                           mx(mx(EXEC_CYC, CLEAR_CYC), INIT_LONG_CYC));
  localparam int W = $clog2(MAXC) + 1;
  localparam logic [2:0] PWRUP = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EHIGH = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] EXEC  = 3'd4;
  localparam logic [2:0] IDLE  = 3'd5;
  localparam logic [7:0] ROM [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [2:0]   state;
  logic [W-1:0] cnt;
  logic [2:0]   idx;
  logic         rs_q;
  logic [7:0]   data_q;
  logic         init_done_q;
  logic         done;
  logic         ready;
  logic [W-1:0] exec_ld;
  assign done  = cnt == '0;
  assign ready = state == IDLE && init_done_q;
  // init 0x30 #0 needs the long wait; clear/home (rs=0, 0x01..0x03) need the clear wait
  assign exec_ld = (!init_done_q && idx == 3'd0) ? W'(INIT_LONG_CYC - 1) :
                   (!rs_q && data_q >= 8'h01 && data_q <= 8'h03) ? W'(CLEAR_CYC - 1) :
                   W'(EXEC_CYC - 1);
  assign bus.cmd_ready = ready;
  assign bus.init_done = init_done_q;
  assign bus.lcd_data  = data_q;
  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_e     = state == EHIGH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWRUP;
      cnt         <= W'(PWRUP_CYC - 1);
      idx         <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      cnt <= done ? cnt : cnt - W'(1);
      case (state)
        PWRUP: if (done) begin
          state  <= SETUP;
          cnt    <= W'(SETUP_CYC - 1);
          idx    <= '0;
          rs_q   <= 1'b0;
          data_q <= ROM[0];
        end
        SETUP: if (done) begin
          state <= EHIGH;
          cnt   <= W'(E_HIGH_CYC - 1);
        end
        EHIGH: if (done) begin
          state <= HOLD;
          cnt   <= W'(HOLD_CYC - 1);
        end
        HOLD: if (done) begin
          state <= EXEC;
          cnt   <= exec_ld;
        end
        EXEC: if (done) begin
          if (init_done_q || idx == 3'd7) begin
            state       <= IDLE;
            init_done_q <= 1'b1;
          end else begin
            state  <= SETUP;
            cnt    <= W'(SETUP_CYC - 1);
            idx    <= idx + 3'd1;
            data_q <= ROM[idx + 3'd1];
          end
        end
        IDLE: if (bus.cmd_valid && ready) begin
          state  <= SETUP;
          cnt    <= W'(SETUP_CYC - 1);
          rs_q   <= bus.cmd_rs;
          data_q <= bus.cmd_data;
        end
        default: state <= PWRUP;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver: directed table-driven check of lcd_bus_driver init sequence, write timing, reset and back-to-back writes
module tb_lcd_bus_driver;
  localparam int PW = 100, SU = 2, EH = 5, HO = 2, EX = 20, CL = 50, IL = 60;
  localparam logic [7:0] ROM [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  localparam int WT [8] = '{IL, EX, EX, EX, EX, CL, EX, EX};
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
    logic       tog;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic rw_bad = 1'b0;
  vec_t tv [8];
  lcd_bus_if bus();
  lcd_bus_driver #(
    .PWRUP_CYC(PW), .SETUP_CYC(SU), .E_HIGH_CYC(EH), .HOLD_CYC(HO),
    .EXEC_CYC(EX), .CLEAR_CYC(CL), .INIT_LONG_CYC(IL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.lcd_rw !== 1'b0) rw_bad = 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // called right after rst_n is released on a negedge
  task automatic run_init();
    int n = 0, np = 0, ew = 0, exp_rise = PW + SU;
    logic pe = 1'b0, z_ok = 1'b1, rdy_early = 1'b0, done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (n < PW && (bus.lcd_data !== 8'h00 || bus.lcd_rs !== 1'b0 || bus.lcd_e !== 1'b0 ||
                     bus.init_done !== 1'b0 || bus.cmd_ready !== 1'b0)) z_ok = 1'b0;
      if (bus.cmd_ready === 1'b1 && bus.init_done !== 1'b1) rdy_early = 1'b1;
      if (bus.lcd_e === 1'b1 && pe !== 1'b1) begin
        if (np < 8) begin
          chk("init_rise_time", n, exp_rise);
          chk("init_data", {24'h0, bus.lcd_data}, {24'h0, ROM[np]});
          chk("init_rs", {31'h0, bus.lcd_rs}, 0);
          exp_rise += EH + HO + WT[np] + SU;
        end
        np++;
        ew = 0;
      end
      if (bus.lcd_e === 1'b1) ew++;
      if (bus.lcd_e !== 1'b1 && pe === 1'b1) chk("init_e_width", ew, EH);
      pe = bus.lcd_e;
      if (bus.init_done === 1'b1) done = 1'b1;
    end
    chk("pwrup_outputs_zero", {31'h0, z_ok}, 1);
    chk("init_pulse_count", np, 8);
    chk("init_done_time", n, exp_rise - SU);
    chk("ready_before_init", {31'h0, rdy_early}, 0);
    chk("ready_after_init", {31'h0, bus.cmd_ready}, 1);
  endtask
  task automatic do_write(input logic rs, input logic [7:0] d, input int gap, input logic tog);
    int n = 0, t = 0, e0 = -1, ew = 0;
    logic stable = 1'b1;
    while (bus.cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_write", {31'h0, bus.cmd_ready}, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs = rs;
    bus.cmd_data = d;
    @(negedge clk);
    bus.cmd_valid = tog;
    chk("data_next", {24'h0, bus.lcd_data}, {24'h0, d});
    chk("rs_next", {31'h0, bus.lcd_rs}, {31'h0, rs});
    chk("ready_drop", {31'h0, bus.cmd_ready}, 0);
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      if (bus.lcd_data !== d || bus.lcd_rs !== rs) stable = 1'b0;
      if (bus.lcd_e === 1'b1) begin
        if (e0 < 0) e0 = n;
        ew++;
      end
      if (tog) begin
        bus.cmd_data = ~bus.cmd_data;
        bus.cmd_rs = ~bus.cmd_rs;
      end
      n++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("ready_gap", n, gap);
    chk("e_start", e0, SU);
    chk("e_width", ew, EH);
    chk("data_stable", {31'h0, stable}, 1);
  endtask
  task automatic b2b();
    int sent = 0, n = 0, np = 0;
    int rt [3] = '{0, 0, 0};
    logic [7:0] rd [3] = '{8'h00, 8'h00, 8'h00};
    logic pr, pe = 1'b0;
    pr = bus.cmd_ready;
    while (n < 300 && !(sent == 3 && bus.cmd_ready === 1'b1)) begin
      @(negedge clk);
      n++;
      if (pr === 1'b1) begin
        sent++;
        if (sent < 3) bus.cmd_data = 8'h31 + 8'(sent);
        else bus.cmd_valid = 1'b0;
      end
      if (bus.lcd_e === 1'b1 && pe !== 1'b1) begin
        if (np < 3) begin
          rt[np] = n;
          rd[np] = bus.lcd_data;
        end
        np++;
      end
      pe = bus.lcd_e;
      pr = bus.cmd_ready;
    end
    chk("b2b_pulses", np, 3);
    chk("b2b_first_rise", rt[0], 1 + SU);
    chk("b2b_d0", {24'h0, rd[0]}, 32'h31);
    chk("b2b_d1", {24'h0, rd[1]}, 32'h32);
    chk("b2b_d2", {24'h0, rd[2]}, 32'h33);
    chk("b2b_spacing1", rt[1] - rt[0], 30);
    chk("b2b_spacing2", rt[2] - rt[1], 30);
    chk("b2b_ready_back", {31'h0, bus.cmd_ready}, 1);
  endtask
  initial begin
    int t;
    tv = '{
      '{1'b1, 8'h34, 29, 1'b0},
      '{1'b0, 8'h01, 59, 1'b0},
      '{1'b1, 8'h01, 29, 1'b0},
      '{1'b0, 8'h00, 29, 1'b0},
      '{1'b0, 8'h02, 59, 1'b1},
      '{1'b0, 8'h03, 59, 1'b0},
      '{1'b0, 8'h04, 29, 1'b0},
      '{1'b1, 8'h41, 29, 1'b1}
    };
    bus.cmd_valid = 1'b0;
    bus.cmd_rs = 1'b0;
    bus.cmd_data = 8'h00;
    @(negedge clk);
    chk("reset_e", {31'h0, bus.lcd_e}, 0);
    chk("reset_data", {24'h0, bus.lcd_data}, 0);
    chk("reset_ready", {31'h0, bus.cmd_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init();
    for (int i = 0; i < 8; i++) do_write(tv[i].rs, tv[i].d, tv[i].gap, tv[i].tog);
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_rs = 1'b1;
    bus.cmd_data = 8'h55;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (bus.lcd_e !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("e_high_before_reset", {31'h0, bus.lcd_e}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_e_drop", {31'h0, bus.lcd_e}, 0);
    chk("rst_ready_drop", {31'h0, bus.cmd_ready}, 0);
    chk("rst_init_done_drop", {31'h0, bus.init_done}, 0);
    chk("rst_data_drop", {24'h0, bus.lcd_data}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_init();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rs = 1'b1;
    bus.cmd_data = 8'h31;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_init();
    b2b();
    chk("rw_never_high", {31'h0, rw_bad}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
